// File: rtl/taskwait_cam_if.sv
// rtl/taskwait_cam_if.sv - taskwait command input stream and accelerator wakeup output stream
interface taskwait_cam_if #(
    parameter int ACC_BITS = 4
);
    logic [63:0]         inStream_TDATA;
    logic                inStream_TVALID;
    logic [ACC_BITS-1:0] inStream_TID;
    logic                inStream_TREADY;
    logic [7:0]          outStream_TDATA;
    logic                outStream_TVALID;
    logic                outStream_TREADY;
    logic [ACC_BITS-1:0] outStream_TDEST;

    modport slave (
        input  inStream_TDATA, inStream_TVALID, inStream_TID, outStream_TREADY,
        output inStream_TREADY, outStream_TDATA, outStream_TVALID, outStream_TDEST
    );

    modport master (
        output inStream_TDATA, inStream_TVALID, inStream_TID, outStream_TREADY,
        input  inStream_TREADY, outStream_TDATA, outStream_TVALID, outStream_TDEST
    );
endinterface

// File: rtl/taskwait_cam.sv
// rtl/taskwait_cam.sv - fully associative pending-taskwait table with wakeup FIFO
module taskwait_cam #(
    parameter int ACC_BITS    = 4,
    parameter int TW_MEM_BITS = 4,
    parameter int COMP_BITS   = 32,
    parameter int WQ_DEPTH    = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    taskwait_cam_if.slave        bus,
    output logic [TW_MEM_BITS:0] occupancy,
    output logic                 err_full
);
    localparam int ENTRIES = 1 << TW_MEM_BITS;
    localparam int PTR_W   = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int CNT_W   = $clog2(WQ_DEPTH + 1);

    localparam logic [1:0] ST_HEADER = 2'd0;
    localparam logic [1:0] ST_TID    = 2'd1;
    localparam logic [1:0] ST_MATCH  = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    logic [1:0] state;

    logic                   is_wait;
    logic [COMP_BITS-1:0]   comps;
    logic [ACC_BITS-1:0]    tid;
    logic [63:0]            cur_id;

    logic [ENTRIES-1:0]     valid;
    logic [63:0]            task_ids [ENTRIES];
    logic [ACC_BITS-1:0]    acc_ids  [ENTRIES];
    logic [COMP_BITS-1:0]   balance  [ENTRIES];

    logic                   hit;
    logic                   slot_free;
    logic [TW_MEM_BITS-1:0] tgt_idx;
    logic [COMP_BITS-1:0]   result;

    logic                   m_hit;
    logic [TW_MEM_BITS-1:0] m_hit_idx;
    logic                   m_free;
    logic [TW_MEM_BITS-1:0] m_free_idx;
    logic [COMP_BITS-1:0]   m_base;
    logic [COMP_BITS-1:0]   m_delta;

    logic [ACC_BITS-1:0]    wq_mem [WQ_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       wq_count;
    logic                   wq_full;
    logic                   push;
    logic                   pop;
    logic [ACC_BITS-1:0]    wake_id;
    logic                   res_zero;
    logic [TW_MEM_BITS:0]   occ_next;

    logic hs;

    assign bus.inStream_TREADY  = !ap_rst && ((state == ST_HEADER) || (state == ST_TID));
    assign hs                   = bus.inStream_TVALID && bus.inStream_TREADY;
    assign bus.outStream_TDATA  = 8'd1;
    assign bus.outStream_TVALID = (wq_count != '0);
    assign bus.outStream_TDEST  = wq_mem[rd_ptr];

    // Parallel compare; free slot loop runs downward so the lowest invalid index wins.
    always_comb begin
        m_hit      = 1'b0;
        m_hit_idx  = '0;
        m_free     = 1'b0;
        m_free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && (task_ids[i] == cur_id)) begin
                m_hit     = 1'b1;
                m_hit_idx = TW_MEM_BITS'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                m_free     = 1'b1;
                m_free_idx = TW_MEM_BITS'(i);
            end
        end
        m_base  = m_hit ? balance[m_hit_idx] : '0;
        m_delta = is_wait ? ('0 - comps) : COMP_BITS'(1);
    end

    assign res_zero = (result == '0);
    assign wq_full  = (wq_count == CNT_W'(WQ_DEPTH));
    assign wake_id  = is_wait ? tid : (hit ? acc_ids[tgt_idx] : '0);
    assign push     = (state == ST_UPDATE) && res_zero && !wq_full;
    assign pop      = (wq_count != '0) && bus.outStream_TREADY;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= ST_HEADER;
            is_wait   <= 1'b0;
            comps     <= '0;
            tid       <= '0;
            cur_id    <= '0;
            hit       <= 1'b0;
            slot_free <= 1'b0;
            tgt_idx   <= '0;
            result    <= '0;
            err_full  <= 1'b0;
            valid     <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                task_ids[i] <= '0;
                acc_ids[i]  <= '0;
                balance[i]  <= '0;
            end
        end else begin
            case (state)
                ST_HEADER: begin
                    if (hs) begin
                        is_wait <= bus.inStream_TDATA[62];
                        comps   <= bus.inStream_TDATA[COMP_BITS-1:0];
                        tid     <= bus.inStream_TID;
                        state   <= ST_TID;
                    end
                end
                ST_TID: begin
                    if (hs) begin
                        cur_id <= bus.inStream_TDATA;
                        state  <= ST_MATCH;
                    end
                end
                ST_MATCH: begin
                    hit       <= m_hit;
                    slot_free <= m_free;
                    tgt_idx   <= m_hit ? m_hit_idx : m_free_idx;
                    result    <= m_base + m_delta;
                    state     <= ST_UPDATE;
                end
                default: begin
                    if (res_zero) begin
                        // A completed taskwait waits here until the wakeup FIFO has room.
                        if (!wq_full) begin
                            if (hit) begin
                                valid[tgt_idx] <= 1'b0;
                            end
                            state <= ST_HEADER;
                        end
                    end else if (hit) begin
                        balance[tgt_idx] <= result;
                        if (is_wait) begin
                            acc_ids[tgt_idx] <= tid;
                        end
                        state <= ST_HEADER;
                    end else if (slot_free) begin
                        valid[tgt_idx]    <= 1'b1;
                        task_ids[tgt_idx] <= cur_id;
                        balance[tgt_idx]  <= result;
                        acc_ids[tgt_idx]  <= is_wait ? tid : '0;
                        state             <= ST_HEADER;
                    end else begin
                        err_full <= 1'b1;
                        state    <= ST_HEADER;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            wq_count <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) begin
                wq_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                wq_mem[wr_ptr] <= wake_id;
                wr_ptr         <= (wr_ptr == PTR_W'(WQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(WQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   wq_count <= wq_count + 1'b1;
                2'b01:   wq_count <= wq_count - 1'b1;
                default: wq_count <= wq_count;
            endcase
        end
    end

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occ_next = occ_next + {{TW_MEM_BITS{1'b0}}, valid[i]};
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end
endmodule

// File: tb/tb_taskwait_cam.sv
// tb/tb_taskwait_cam.sv - directed table, corner sequences and random model check for taskwait_cam
module tb_taskwait_cam;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] occupancy;
    logic       err_full;

    taskwait_cam_if #(.ACC_BITS(4)) bus ();

    taskwait_cam #(.ACC_BITS(4), .TW_MEM_BITS(4), .COMP_BITS(32), .WQ_DEPTH(4)) dut (
        .ap_clk(clk), .ap_rst(rst), .bus(bus), .occupancy(occupancy), .err_full(err_full)
    );

    always #5 clk = ~clk;

    logic rand_rdy = 1'b0;
    logic rdy_force = 1'b1;
    logic rand_bit = 1'b1;
    always @(posedge clk) begin
        #1 rand_bit = 1'($urandom % 2);
    end
    assign bus.outStream_TREADY = rand_rdy ? rand_bit : rdy_force;

    int vectors = 0;
    int miscompares = 0;

    // Observed wakeups, recorded only by the monitor.
    logic [3:0] obs_dest [256];
    logic [7:0] obs_data [256];
    int obs_n = 0;
    always @(negedge clk) begin
        if (!rst && bus.outStream_TVALID && bus.outStream_TREADY) begin
            obs_dest[obs_n % 256] = bus.outStream_TDEST;
            obs_data[obs_n % 256] = bus.outStream_TDATA;
            obs_n++;
        end
    end

    // Reference model: table of pending taskwaits and the expected wakeup order.
    bit         m_valid [16];
    bit [63:0]  m_id    [16];
    bit [3:0]   m_acc   [16];
    bit [31:0]  m_bal   [16];
    bit         m_err;
    bit [3:0]   exp_q [$];
    int         chk_n = 0;

    typedef struct {
        bit        w;
        int        comps;
        bit [3:0]  tid;
        bit [63:0] id;
        int        exp_occ;
        int        exp_wakes;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_id[i] = 0; m_acc[i] = 0; m_bal[i] = 0;
        end
        m_err = 0;
        exp_q.delete();
    endfunction

    function automatic void model_msg(input bit w, input int comps, input bit [3:0] tid, input bit [63:0] id);
        int hit = -1;
        int fr = -1;
        bit [31:0] res;
        for (int i = 0; i < 16; i++) if (m_valid[i] && m_id[i] == id) hit = i;
        for (int i = 15; i >= 0; i--) if (!m_valid[i]) fr = i;
        res = (hit >= 0 ? m_bal[hit] : 32'd0) + (w ? -comps : 1);
        if (res == 0) begin
            exp_q.push_back(w ? tid : (hit >= 0 ? m_acc[hit] : 4'd0));
            if (hit >= 0) m_valid[hit] = 0;
        end else if (hit >= 0) begin
            m_bal[hit] = res;
            if (w) m_acc[hit] = tid;
        end else if (fr >= 0) begin
            m_valid[fr] = 1; m_id[fr] = id; m_bal[fr] = res; m_acc[fr] = w ? tid : 4'd0;
        end else begin
            m_err = 1;
        end
    endfunction

    task automatic check_wakes();
        while (chk_n < obs_n) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_wake: got tdest %0h expected none", obs_dest[chk_n % 256]);
            end else begin
                check("wake_tdest", 64'(obs_dest[chk_n % 256]), 64'(exp_q.pop_front()));
                check("wake_tdata", 64'(obs_data[chk_n % 256]), 64'd1);
            end
            chk_n++;
        end
    endtask

    task automatic put_word(input logic [63:0] d, input logic [3:0] t);
        int n = 0;
        @(posedge clk); #1;
        bus.inStream_TDATA = d; bus.inStream_TID = t; bus.inStream_TVALID = 1'b1;
        @(negedge clk);
        while (!bus.inStream_TREADY && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) begin
            vectors++; miscompares++;
            $display("FAIL in_handshake_timeout: got tready 0 expected 1");
        end
        @(posedge clk); #1;
        bus.inStream_TVALID = 1'b0;
    endtask

    task automatic send_msg(input bit w, input int comps, input bit [3:0] t, input bit [63:0] id);
        logic [63:0] hdr;
        hdr = 64'(unsigned'(comps));
        hdr[62] = w;
        put_word(hdr, t);
        put_word(id, 4'd0);
        model_msg(w, comps, t, id);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!bus.inStream_TREADY && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) begin
            vectors++; miscompares++;
            $display("FAIL idle_timeout: got tready 0 expected 1");
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic apply_reset(input bit check_vals);
        check_wakes();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_in_tready", 64'(bus.inStream_TREADY), 64'd0);
        if (check_vals) begin
            check("rst_tvalid", 64'(bus.outStream_TVALID), 64'd0);
            check("rst_tdest", 64'(bus.outStream_TDEST), 64'd0);
            check("rst_occupancy", 64'(occupancy), 64'd0);
            check("rst_err_full", 64'(err_full), 64'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        chk_n = obs_n;
        model_clear();
        @(negedge clk);
        check("post_rst_in_tready", 64'(bus.inStream_TREADY), 64'd1);
    endtask

    initial begin
        int base;
        int prev;
        bus.inStream_TDATA = '0; bus.inStream_TID = '0; bus.inStream_TVALID = 1'b0;
        model_clear();

        tbl[0] = '{1, 2, 4'd3, 64'h10, 1, 0};
        tbl[1] = '{0, 0, 4'd0, 64'h10, 1, 0};
        tbl[2] = '{0, 0, 4'd0, 64'h10, 0, 1};
        tbl[3] = '{0, 0, 4'd0, 64'h20, 1, 1};
        tbl[4] = '{0, 0, 4'd0, 64'h20, 1, 1};
        tbl[5] = '{0, 0, 4'd0, 64'h20, 1, 1};
        tbl[6] = '{1, 3, 4'd5, 64'h20, 0, 2};
        tbl[7] = '{1, 0, 4'd7, 64'h30, 0, 3};

        repeat (2) @(posedge clk);
        apply_reset(1);

        base = obs_n;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            send_msg(tbl[i].w, tbl[i].comps, tbl[i].tid, tbl[i].id);
            if (tbl[i].exp_wakes != prev) begin
                @(negedge clk); check("tvalid_match_cycle", 64'(bus.outStream_TVALID), 64'd0);
                @(negedge clk); check("tvalid_update_cycle", 64'(bus.outStream_TVALID), 64'd0);
                @(negedge clk); check("tvalid_t4", 64'(bus.outStream_TVALID), 64'd1);
                settle(2);
            end else begin
                settle(4);
            end
            prev = tbl[i].exp_wakes;
            check("tbl_occupancy", 64'(occupancy), 64'(tbl[i].exp_occ));
            check("tbl_wake_count", 64'(obs_n - base), 64'(tbl[i].exp_wakes));
            check_wakes();
        end

        // Overflow: 16 distinct ids fill the table, the 17th is dropped.
        apply_reset(0);
        for (int i = 0; i < 16; i++) send_msg(0, 0, 4'd0, 64'h100 + 64'(i));
        settle(4);
        check("fill_occupancy", 64'(occupancy), 64'd16);
        check("fill_err", 64'(err_full), 64'd0);
        send_msg(0, 0, 4'd0, 64'h1FF);
        settle(4);
        check("ovf_occupancy", 64'(occupancy), 64'd16);
        check("ovf_err", 64'(err_full), 64'(m_err));
        send_msg(0, 0, 4'd0, 64'h100);
        send_msg(1, 2, 4'd6, 64'h100);
        settle(6);
        check("ovf_existing_occupancy", 64'(occupancy), 64'd15);
        check("ovf_err_sticky", 64'(err_full), 64'd1);
        check_wakes();

        // Lowest free index is reused.
        apply_reset(0);
        for (int i = 0; i < 4; i++) send_msg(0, 0, 4'd0, 64'hA0 + 64'(i));
        send_msg(1, 1, 4'd2, 64'hA0);
        send_msg(0, 0, 4'd0, 64'h55);
        settle(6);
        check("realloc_occupancy", 64'(occupancy), 64'd4);
        check("realloc_idx0_valid", 64'(dut.valid[0]), 64'd1);
        check("realloc_idx0_id", dut.task_ids[0], 64'h55);
        check_wakes();

        // Wakeup FIFO backpressure.
        apply_reset(0);
        rdy_force = 1'b0;
        base = obs_n;
        for (int k = 1; k <= 5; k++) send_msg(1, 0, 4'(k), 64'h400 + 64'(k));
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_tready", 64'(bus.inStream_TREADY), 64'd0);
            check("stall_tvalid", 64'(bus.outStream_TVALID), 64'd1);
            check("stall_tdest", 64'(bus.outStream_TDEST), 64'd1);
        end
        @(posedge clk); #1 rdy_force = 1'b1;
        settle(12);
        check("stall_wake_count", 64'(obs_n - base), 64'd5);
        check("stall_occupancy", 64'(occupancy), 64'd0);
        check_wakes();

        // Reset between header and task id.
        apply_reset(0);
        base = obs_n;
        put_word({1'b0, 1'b1, 62'd0}, 4'd9);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_in_tready", 64'(bus.inStream_TREADY), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_post_tready", 64'(bus.inStream_TREADY), 64'd1);
        settle(6);
        check("midrst_occupancy", 64'(occupancy), 64'd0);
        check("midrst_no_wake", 64'(obs_n - base), 64'd0);
        send_msg(1, 0, 4'd9, 64'h77);
        settle(6);
        check("midrst_restart_wake", 64'(obs_n - base), 64'd1);
        check_wakes();

        // Random traffic with random wakeup backpressure.
        apply_reset(0);
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_msg(($urandom % 3) == 0, int'($urandom % 4), 4'($urandom % 16),
                     64'h300 + 64'($urandom % 6));
            wait_idle();
            check("rand_occupancy", 64'(occupancy), 64'(model_count()));
            check("rand_err", 64'(err_full), 64'(m_err));
        end
        rand_rdy = 1'b0;
        settle(12);
        check_wakes();
        check("rand_wakes_pending", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/taskwait_cam.md
# taskwait_cam

Parametrised taskwait tracker for the extended OmpSs manager. It sits between the taskwait command stream (child-finished and accelerator-wait messages) and the accelerator wakeup stream. It keeps a fully associative table of pending taskwaits indexed by task id and matches all entries in one cycle. A wakeup FIFO lets new messages proceed while the wakeup output is stalled, and a sticky error is raised when the table overflows.

## Interface
Parameters:
- ACC_BITS, 4, accelerator id width (TID/TDEST).
- TW_MEM_BITS, 4, log2 of table entries (2^TW_MEM_BITS entries).
- COMP_BITS, 32, balance/components width, 1..32.
- WQ_DEPTH, 4, wakeup FIFO depth, ≥1.

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- inStream_TDATA  in  64  header word, then task-id word.
- inStream_TVALID  in  1  input valid.
- inStream_TID  in  ACC_BITS  sender accelerator id, sampled with the header.
- inStream_TREADY  out  1  input ready.
- outStream_TDATA  out  8  constant 8'd1.
- outStream_TVALID  out  1  wakeup valid.
- outStream_TREADY  in  1  wakeup ready.
- outStream_TDEST  out  ACC_BITS  accelerator to wake.
- occupancy  out  TW_MEM_BITS+1  number of valid table entries.
- err_full  out  1  sticky overflow flag.

## Operation
- Header fields: TYPE = TDATA[62]; COMPS = TDATA[COMP_BITS-1:0].
  - TYPE=0 is FINISH: one child done, delta +1.
  - TYPE=1 is WAIT: the sender waits on COMPS children, delta −COMPS.
- Table entry fields: valid, task_id[63:0], acc_id[ACC_BITS], balance[COMP_BITS].
- States and transitions:
  - READ_HEADER: TREADY=1. On a handshake, latch TYPE, COMPS and TID, then go to READ_TID.
  - READ_TID: TREADY=1. On a handshake, latch task_id, then go to MATCH.
  - MATCH: compare task_id against all valid entries in parallel.
    - Hit: base = entry balance.
    - Miss: base = 0, and the free slot is the lowest-index invalid entry.
    - Register result = base + delta, mod 2^COMP_BITS. Go to UPDATE.
  - UPDATE, target = hit index or free slot. Wake id = TID if WAIT, else the stored acc_id.
    - result==0, wakeup FIFO not full: push the wake id and clear valid on a hit entry. On a miss nothing is allocated. Go to READ_HEADER.
    - result==0, FIFO full: hold in UPDATE, TREADY=0, no table change.
    - result!=0, hit: write the balance. If WAIT, also write acc_id=TID. Go to READ_HEADER.
    - result!=0, miss, slot free: allocate with valid=1, task_id, balance=result, and acc_id=TID if WAIT, else 0. Go to READ_HEADER.
    - result!=0, miss, table full: drop the message and set err_full. Go to READ_HEADER.
- Task ids are never duplicated in the table; at most one hit.
- occupancy is a registered count of valid bits, updated in the cycle after UPDATE.
- err_full is cleared only by reset.

## Timing
- Reset values:
  - inStream_TREADY=0 while ap_rst=1, then 1 (READ_HEADER).
  - outStream_TVALID=0, outStream_TDEST=0, occupancy=0, err_full=0.
  - All valid bits 0, FIFO empty.
- Reset mid-message aborts with no table write. The partial message is lost, and the sender restarts with a header.
- Header accepted at cycle t, earliest task id at t+1, MATCH at t+2, UPDATE at t+3, next header at t+4. Throughput is 4 cycles per message unstalled.
- Wakeup output:
  - outStream_TVALID = FIFO not empty, with TDEST = FIFO head.
  - A push in UPDATE at cycle u makes the entry visible at u+1.
  - Pop on TVALID && TREADY. TDATA/TDEST stay stable while TVALID && !TREADY.
  - Push and pop in the same cycle both take effect.
  - FIFO fullness is judged at the start of the cycle, so a same-cycle pop does not unblock a push.
- A WAIT with COMPS=0 and no entry gives result 0: immediate wakeup to TID, no allocation.
- A WAIT when the entry's balance already equals COMPS (all children already finished): wakeup to TID, entry freed.
- Balance wrap is modular and is not flagged.

## Test plan
- Reset, then WAIT(id=0x10, COMPS=2, TID=3), FINISH(0x10), FINISH(0x10) -> occupancy goes 1,1,0; exactly one wakeup with TDEST=3, TDATA=1, after the third UPDATE.
- FINISH(0x20) ×3, then WAIT(0x20, COMPS=3, TID=5) -> entry balance 3; wakeup TDEST=5 at t+4 of the WAIT header; occupancy returns to 0.
- Fill all 16 entries with FINISH on distinct ids, then FINISH on a new id -> message dropped, err_full=1, occupancy=16. FINISH on an existing id still updates, and err_full stays 1.
- Hold outStream_TREADY=0 and issue 5 completing WAITs (COMPS=0, TIDs 1..5) with WQ_DEPTH=4 -> 4 accepted, the 5th stalls in UPDATE with TREADY=0. Releasing TREADY delivers TDEST 1,2,3,4,5 in order.
- Assert ap_rst between the header and task-id words of a WAIT -> no wakeup, occupancy=0; TREADY is 0 during reset and 1 on the cycle after deassertion.
- Free entry 0 among valid entries 1..3, then allocate a new id -> the new entry lands in index 0, chosen by lowest free index.
